// File: rtl/score_pkg.sv
// Shared constants for the pong score tracker: score width,
// seven-segment codes, END banner glyphs and digit helpers.
package score_pkg;

   localparam int SCORE_W = 5;
   localparam logic [SCORE_W-1:0] SCORE_MAX = 5'd31;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;

   localparam int BAN_SCALE = 4;
   localparam int BAN_PITCH = 24;
   localparam int BAN_W     = 68;
   localparam int BAN_H     = 28;
   localparam int GLYPH_W   = 5 * BAN_SCALE;

   // [char][row][col]; char 0..2 = E,N,D, row 0 = top, bit 4 = left
   localparam logic [0:2][0:6][4:0] END_ROM = {
      5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F,
      5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11, 5'h11,
      5'h1E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h1E
   };

   function automatic logic [3:0] tens_of(input logic [SCORE_W-1:0] s);
      if (s >= 5'd30)      return 4'd3;
      else if (s >= 5'd20) return 4'd2;
      else if (s >= 5'd10) return 4'd1;
      else                 return 4'd0;
   endfunction

   function automatic logic [3:0] ones_of(input logic [SCORE_W-1:0] s);
      if (s >= 5'd30)      return 4'(s - 5'd30);
      else if (s >= 5'd20) return 4'(s - 5'd20);
      else if (s >= 5'd10) return 4'(s - 5'd10);
      else                 return 4'(s);
   endfunction

endpackage

// File: rtl/score_tracker_if.sv
// Bundle between game logic / pixel mux (master) and the
// score tracker (slave).
interface score_tracker_if;
   import score_pkg::*;

   logic               hit_right;
   logic               hit_left;
   logic               clear;
   logic [SCORE_W-1:0] max_score;
   logic [9:0]         x;
   logic [9:0]         y;
   logic [SCORE_W-1:0] score_p1;
   logic [SCORE_W-1:0] score_p2;
   logic [6:0]         p1_tens_seg;
   logic [6:0]         p1_ones_seg;
   logic [6:0]         p2_tens_seg;
   logic [6:0]         p2_ones_seg;
   logic               game_over;
   logic               endgame_pix;

   modport master (
      output hit_right, hit_left, clear, max_score, x, y,
      input  score_p1, score_p2,
      input  p1_tens_seg, p1_ones_seg, p2_tens_seg, p2_ones_seg,
      input  game_over, endgame_pix
   );

   modport slave (
      input  hit_right, hit_left, clear, max_score, x, y,
      output score_p1, score_p2,
      output p1_tens_seg, p1_ones_seg, p2_tens_seg, p2_ones_seg,
      output game_over, endgame_pix
   );

endinterface

// File: rtl/digit_seg_enc.sv
// Decimal digit to active-high seven-segment code (bit0=a .. bit6=g).
module digit_seg_enc
   import score_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = 7'h00;
      case (i_digit)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = 7'h00;
      endcase
   end

endmodule

// File: rtl/score_tracker.sv
// Pong score counters, 7-seg digit outputs, game-over flag and END banner.
// Define SCORE_SATURATE_EN to hold scores at 31 instead of wrapping.
module score_tracker
   import score_pkg::*;
#(
   parameter int ENDX = 276,
   parameter int ENDY = 220
)
(
   input  logic            clk,
   input  logic            reset_n,
   score_tracker_if.slave  bus
);

   localparam logic [9:0] LX = 10'(ENDX);
   localparam logic [9:0] RX = 10'(ENDX + BAN_W);
   localparam logic [9:0] TY = 10'(ENDY);
   localparam logic [9:0] BY = 10'(ENDY + BAN_H);

   logic               r_hist_r;
   logic               r_hist_l;
   logic [SCORE_W-1:0] r_score_p1;
   logic [SCORE_W-1:0] r_score_p2;
   logic [6:0]         r_p1_tens_seg;
   logic [6:0]         r_p1_ones_seg;
   logic [6:0]         r_p2_tens_seg;
   logic [6:0]         r_p2_ones_seg;
   logic               r_game_over;
   logic               r_pix;

   logic               w_rise_r;
   logic               w_rise_l;
   logic [6:0]         w_p1_tens_seg;
   logic [6:0]         w_p1_ones_seg;
   logic [6:0]         w_p2_tens_seg;
   logic [6:0]         w_p2_ones_seg;
   logic               w_game_over;

   function automatic logic [SCORE_W-1:0] f_inc(input logic [SCORE_W-1:0] s);
`ifdef SCORE_SATURATE_EN
      return (s == SCORE_MAX) ? s : s + 1'b1;
`else
      return s + 1'b1;
`endif
   endfunction

   assign w_rise_r = bus.hit_right & ~r_hist_r;
   assign w_rise_l = bus.hit_left  & ~r_hist_l;

   // History resets high so a hit held through reset release is ignored
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_hist_r   <= 1'b1;
         r_hist_l   <= 1'b1;
         r_score_p1 <= '0;
         r_score_p2 <= '0;
      end else begin
         r_hist_r <= bus.hit_right;
         r_hist_l <= bus.hit_left;
         if (bus.clear) begin
            r_score_p1 <= '0;
            r_score_p2 <= '0;
         end else begin
            if (w_rise_r) r_score_p1 <= f_inc(r_score_p1);
            if (w_rise_l) r_score_p2 <= f_inc(r_score_p2);
         end
      end
   end

   digit_seg_enc u_p1_tens (.i_digit(tens_of(r_score_p1)), .o_seg(w_p1_tens_seg));
   digit_seg_enc u_p1_ones (.i_digit(ones_of(r_score_p1)), .o_seg(w_p1_ones_seg));
   digit_seg_enc u_p2_tens (.i_digit(tens_of(r_score_p2)), .o_seg(w_p2_tens_seg));
   digit_seg_enc u_p2_ones (.i_digit(ones_of(r_score_p2)), .o_seg(w_p2_ones_seg));

   assign w_game_over = (bus.max_score != '0) &&
                        ((r_score_p1 == bus.max_score) ||
                         (r_score_p2 == bus.max_score));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_p1_tens_seg <= SEG_0;
         r_p1_ones_seg <= SEG_0;
         r_p2_tens_seg <= SEG_0;
         r_p2_ones_seg <= SEG_0;
         r_game_over   <= 1'b0;
      end else begin
         r_p1_tens_seg <= w_p1_tens_seg;
         r_p1_ones_seg <= w_p1_ones_seg;
         r_p2_tens_seg <= w_p2_tens_seg;
         r_p2_ones_seg <= w_p2_ones_seg;
         r_game_over   <= w_game_over;
      end
   end

   logic       w_in_box;
   logic [9:0] w_dx;
   logic [1:0] w_char;
   logic [9:0] w_off;
   logic [4:0] w_in_ch;
   logic       w_gap;
   logic [2:0] w_col;
   logic [2:0] w_row;
   logic       w_bit;

   // Banner: 24-px character cells, the last 4 px of each cell are blank
   always_comb begin
      w_in_box = (bus.x >= LX) && (bus.x < RX) &&
                 (bus.y >= TY) && (bus.y < BY);
      w_dx     = bus.x - LX;
      if (w_dx >= 10'(2 * BAN_PITCH))  w_char = 2'd2;
      else if (w_dx >= 10'(BAN_PITCH)) w_char = 2'd1;
      else                             w_char = 2'd0;
      w_off    = 10'(BAN_PITCH) * 10'(w_char);
      w_in_ch  = 5'(w_dx - w_off);
      w_gap    = (w_in_ch >= 5'(GLYPH_W));
      w_col    = 3'(w_in_ch >> 2);
      w_row    = 3'((bus.y - TY) >> 2);
      w_bit    = END_ROM[w_char][w_row][3'(3'd4 - w_col)];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) r_pix <= 1'b0;
      else          r_pix <= w_in_box & ~w_gap & w_bit;
   end

   assign bus.score_p1    = r_score_p1;
   assign bus.score_p2    = r_score_p2;
   assign bus.p1_tens_seg = r_p1_tens_seg;
   assign bus.p1_ones_seg = r_p1_ones_seg;
   assign bus.p2_tens_seg = r_p2_tens_seg;
   assign bus.p2_ones_seg = r_p2_ones_seg;
   assign bus.game_over   = r_game_over;
   assign bus.endgame_pix = r_pix;

endmodule

// File: tb/tb_score_tracker.sv
// Scoreboard bench for score_tracker: driver + reference model push
// expected outputs, a negedge monitor pops and compares.
module tb_score_tracker;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   score_tracker_if bus();

   score_tracker #(.ENDX(276), .ENDY(220)) dut (
      .clk(clk),
      .reset_n(rst_n),
      .bus(bus)
   );

   typedef struct {
      int s1, s2, t1, o1, t2, o2, go, pix;
   } exp_t;

   exp_t q[$];
   int n_checks = 0;
   int n_fail = 0;

   int SEG[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
   int GLY[21] = '{'h1F, 'h10, 'h10, 'h1E, 'h10, 'h10, 'h1F,
                   'h11, 'h19, 'h15, 'h13, 'h11, 'h11, 'h11,
                   'h1E, 'h11, 'h11, 'h11, 'h11, 'h11, 'h1E};

   int m_s1 = 0, m_s2 = 0;
   bit m_ph_r = 1, m_ph_l = 1;
   int g_max = 0, g_x = 0, g_y = 0;

   function automatic int inc(int s);
`ifdef SCORE_SATURATE_EN
      return (s >= 31) ? 31 : s + 1;
`else
      return (s + 1) % 32;
`endif
   endfunction

   function automatic int banner(int xx, int yy);
      int dx, dy, c, w;
      dx = xx - 276;
      dy = yy - 220;
      if (dx < 0 || dx >= 68 || dy < 0 || dy >= 28) return 0;
      c = dx / 24;
      w = dx % 24;
      if (w >= 20) return 0;
      return (GLY[c * 7 + dy / 4] >> (4 - w / 4)) & 1;
   endfunction

   task automatic cyc(input bit rst, input bit hr, input bit hl, input bit clr);
      exp_t e;
      rst_n         = rst;
      bus.hit_right = hr;
      bus.hit_left  = hl;
      bus.clear     = clr;
      bus.max_score = 5'(g_max);
      bus.x         = 10'(g_x);
      bus.y         = 10'(g_y);
      @(posedge clk);
      #1;
      if (!rst) begin
         e.t1 = 'h3F; e.o1 = 'h3F; e.t2 = 'h3F; e.o2 = 'h3F;
         e.go = 0; e.pix = 0;
         m_s1 = 0; m_s2 = 0; m_ph_r = 1; m_ph_l = 1;
      end else begin
         e.t1 = SEG[m_s1 / 10]; e.o1 = SEG[m_s1 % 10];
         e.t2 = SEG[m_s2 / 10]; e.o2 = SEG[m_s2 % 10];
         e.go = (g_max != 0 && (m_s1 == g_max || m_s2 == g_max)) ? 1 : 0;
         e.pix = banner(g_x, g_y);
         if (clr) begin
            m_s1 = 0; m_s2 = 0;
         end else begin
            if (hr && !m_ph_r) m_s1 = inc(m_s1);
            if (hl && !m_ph_l) m_s2 = inc(m_s2);
         end
         m_ph_r = hr; m_ph_l = hl;
      end
      e.s1 = m_s1; e.s2 = m_s2;
      q.push_back(e);
   endtask

   task automatic pulses(input int n, input bit r, input bit l);
      for (int i = 0; i < n; i++) begin
         cyc(1, r, l, 0);
         cyc(1, 0, 0, 0);
      end
   endtask

   task automatic chk(input string nm, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("score_p1", int'(bus.score_p1), e.s1);
         chk("score_p2", int'(bus.score_p2), e.s2);
         chk("p1_tens_seg", int'(bus.p1_tens_seg), e.t1);
         chk("p1_ones_seg", int'(bus.p1_ones_seg), e.o1);
         chk("p2_tens_seg", int'(bus.p2_tens_seg), e.t2);
         chk("p2_ones_seg", int'(bus.p2_ones_seg), e.o2);
         chk("game_over", int'(bus.game_over), e.go);
         chk("endgame_pix", int'(bus.endgame_pix), e.pix);
      end
   end

   int px[6] = '{276, 296, 300, 344, 279, 340};
   int py[6] = '{220, 220, 224, 220, 247, 247};

   initial begin
      bus.hit_right = 0; bus.hit_left = 0; bus.clear = 0;
      bus.max_score = 0; bus.x = 0; bus.y = 0;

      cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      for (int i = 0; i < 100; i++) cyc(1, 1, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);

      pulses(12, 0, 1);
      cyc(1, 0, 0, 0);

      pulses(1, 1, 1);
      cyc(1, 1, 0, 1);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);

      g_max = 3;
      cyc(1, 0, 0, 1);
      pulses(3, 1, 0);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 0);
      g_max = 0;
      pulses(5, 1, 1);
      cyc(1, 0, 0, 1);

      pulses(33, 1, 0);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);

      for (int i = 0; i < 6; i++) begin
         g_x = px[i]; g_y = py[i];
         cyc(1, 0, 0, 0);
      end

      for (int i = 0; i < 3000; i++) begin
         bit r, l, c, rs;
         g_x = $urandom_range(260, 360);
         g_y = $urandom_range(210, 255);
         if ($urandom_range(0, 49) == 0) g_max = $urandom_range(0, 31);
         r  = ($urandom_range(0, 2) == 0);
         l  = ($urandom_range(0, 2) == 0);
         c  = ($urandom_range(0, 199) == 0);
         rs = ($urandom_range(0, 499) != 0);
         cyc(rs, r, l, c);
      end

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      #1;
      chk("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/score_tracker.md
# score_tracker

Keeps both players' points for the pong game and flags when either player reaches the configured target. It turns each score into two-digit seven-segment patterns for the on-screen score overlay and generates the "END" banner pixel for the end-game screen. It sits between the ball/state logic (hit pulses, clear) and the pixel colour mux (x/y in, pixel flags out).

## Interface
- ENDX, 276: left x of the END banner.
- ENDY, 220: top y of the END banner.
- clk  in  1  pixel-domain clock; all state on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- hit_right  in  1  level; ball reached the right wall; scores for P1.
- hit_left  in  1  level; ball reached the left wall; scores for P2.
- clear  in  1  synchronous score clear (new game).
- max_score  in  5  target score (binary).
- x  in  10  current pixel column.
- y  in  10  current pixel row.
- score_p1, score_p2  out  5  binary scores.
- p1_tens_seg, p1_ones_seg, p2_tens_seg, p2_ones_seg  out  7  active-high segments, bit0=a … bit6=g.
- game_over  out  1  a score equals max_score.
- endgame_pix  out  1  (x,y) lies on a lit END banner pixel.

## Operation
- Each hit input is edge-detected against a 1-bit history register.
- A 0→1 transition adds one to that player's score. A held level adds nothing more.
- If hit_right and hit_left rise in the same cycle, both scores increment.
- clear=1 forces both scores to 0 and has priority over any hit in the same cycle. History registers still update while clear is high.
- Score arithmetic is 5-bit unsigned. At 31, the counter follows the rule in Configuration.
- Digit split: tens = score/10, ones = score%10. Range is 0..31, so tens is 0..3.
- The tens digit is always displayed; a 0 shows as "0" (no blanking).
- Segment codes (hex, g..a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- game_over = (max_score != 0) && (score_p1 == max_score || score_p2 == max_score). When max_score = 0, game_over never asserts.
- END banner:
  - Font is 5×7, each font pixel scaled 4× to 20×28 screen pixels.
  - Character pitch is 24 px; characters are E, N, D.
  - Banner spans x ∈ [ENDX, ENDX+68) and y ∈ [ENDY, ENDY+28).
  - Glyph rows, top to bottom, MSB = leftmost column:
    - E: 1F,10,10,1E,10,10,1F
    - N: 11,19,15,13,11,11,11
    - D: 1E,11,11,11,11,11,1E
  - The 4-px gap between characters is always 0.

## Timing
- On reset (reset_n=0 at a clk edge):
  - scores = 0; game_over = 0.
  - All seg outputs = 3F (digit 0).
  - History registers = 1, so a hit already high when reset releases is not counted.
- Hit latency: a rising edge is sampled at edge N; the score changes at edge N+1.
- seg outputs and game_over are registered from the scores, one cycle behind them. Total hit → seg latency is 2 cycles.
- endgame_pix is registered one cycle after x/y. The pixel mux must compensate.
- clear latency: scores read 0 one cycle after clear is sampled.
- Reset mid-game: reset_n low overrides clear and hits.

## Configuration
- SCORE_SATURATE_EN defined: each counter holds at 31 on further hits.
- SCORE_SATURATE_EN undefined: 31 + 1 wraps to 0.

## Structure
- Package score_pkg holds:
  - SCORE_W = 5.
  - The ten seven-segment constants.
  - The END glyph ROM rows.
  - Banner geometry constants: scale 4, pitch 24, width 68, height 28.
- One sub-module, digit_seg_enc (4-bit digit → 7-bit segments, combinational), instantiated four times.
- Counters, edge detect, compare and banner logic stay at the top level.

## Test plan
- Reset release with hit_right held high, then held high for 100 cycles → score_p1 stays 0. Drop it, then pulse high → score_p1 = 1 at the next edge; p1_ones_seg = 06 one cycle later.
- 12 pulses on hit_left → score_p2 = 12; p2_tens_seg = 06; p2_ones_seg = 5B.
- hit_left and hit_right rise in the same cycle → both scores +1. hit_right rising together with clear=1 → both scores read 0.
- max_score = 3, three hit_right pulses → game_over = 1 one cycle after score_p1 = 3. Then clear → game_over = 0. With max_score = 0, no scores ever assert game_over.
- 33 hit_right pulses → score_p1 = 31 with SCORE_SATURATE_EN defined; score_p1 = 1 without it.
- Banner pixels, one cycle after x/y (ENDX=276, ENDY=220):
  - (276,220) → 1, E top-left.
  - (296,220) → 0, gap.
  - (300,224) → 1, N left column.
  - (344,220) → 0, outside the banner.
